instr_mem_hs: RTL and testbench

Parametrised, synchronous-read instruction memory with a valid/ready fetch handshake, a configurable wait-state count and a program-load write port. It replaces the combinational pc-to-instruction ROM between the fetch stage and instruction decode. It supports multi-cycle memory latency and runtime program loading, and it flags out-of-range fetches.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_array.sv | 33 +++
 rtl/instr_mem_hs.sv | 125 ++++++++++++
 tb/tb_instr_mem_hs.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the handshaked instruction memory.
// Holds the fetch FSM states, default NOP and wait-counter sizing.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_t;

  localparam logic [15:0] NOP_DEFAULT = 16'h0000;

  function automatic int cnt_w(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read-first port, one write port.
// The read register resets so the response bus starts at zero.
module imem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read samples the pre-write word on a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_mem_hs.sv
// Fetch-side instruction memory with valid/ready handshake,
// configurable wait states, program-load port and range fault.
module instr_mem_hs
  import imem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] NOP_WORD =
    DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int CW = cnt_w(WAIT_STATES);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [CW-1:0] WS_L = CW'(WAIT_STATES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  imem_state_t       state;
  imem_state_t       nstate;
  logic [ADDR_W-1:0] pc_q;
  logic [CW-1:0]     cnt_q;
  logic              fault_q;
  logic              busy_q;
  logic              accept;
  logic              rd_step;
  logic [ADDR_W-1:0] rd_pc;
  logic              rd_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  assign req_ready = (state == IDLE) ||
                     ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // Zero wait states read straight from the request pc.
  always_comb begin
    nstate  = state;
    rd_step = 1'b0;
    rd_pc   = pc_q;
    if (accept) begin
      if (WAIT_STATES == 0) begin
        rd_step = 1'b1;
        rd_pc   = req_pc;
        nstate  = RESP;
      end else begin
        nstate  = WAIT;
      end
    end else begin
      unique case (state)
        IDLE: nstate = IDLE;
        WAIT: begin
          if (cnt_q == ONE) begin
            rd_step = 1'b1;
            nstate  = RESP;
          end
        end
        RESP: begin
          if (rsp_ready) nstate = IDLE;
        end
        default: nstate = IDLE;
      endcase
    end
  end

  assign rd_ok = {1'b0, rd_pc} < DEPTH_L;
  assign wr_ok = ld_en && ({1'b0, ld_addr} < DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state  <= nstate;
      busy_q <= (nstate != IDLE);
      if (accept) begin
        pc_q  <= req_pc;
        cnt_q <= WS_L;
      end else if (state == WAIT) begin
        cnt_q <= cnt_q - ONE;
      end
      if (rd_step) fault_q <= !rd_ok;
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_step && rd_ok),
    .rd_addr (rd_pc[AW-1:0]),
    .rd_data (rd_data),
    .wr_en   (wr_ok),
    .wr_addr (ld_addr[AW-1:0]),
    .wr_data (ld_data)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_fault = fault_q;
  assign rsp_instr = fault_q ? NOP_WORD : rd_data;
  assign busy      = busy_q;

endmodule

// File: tb/tb_instr_mem_hs.sv
// Directed bench: one wait-state instance plus a zero-wait
// instance for streaming; both share clock, reset and load bus.
module tb_instr_mem_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  logic        rv = 1'b0, rr, sv, srdy = 1'b0, flt, bsy;
  logic [15:0] pc = '0, ins;
  logic        rv0 = 1'b0, rr0, sv0, srdy0 = 1'b0, flt0, bsy0;
  logic [15:0] pc0 = '0, ins0;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [15:0] model [16];

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic        fault;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  instr_mem_hs #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv), .req_ready(rr), .req_pc(pc),
    .rsp_valid(sv), .rsp_ready(srdy),
    .rsp_instr(ins), .rsp_fault(flt),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(bsy)
  );

  instr_mem_hs #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv0), .req_ready(rr0), .req_pc(pc0),
    .rsp_valid(sv0), .rsp_ready(srdy0),
    .rsp_instr(ins0), .rsp_fault(flt0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(bsy0)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic load(input logic [15:0] a,
                      input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    if (a < 16) model[a] = d;
  endtask

  task automatic fetch(input string nm,
                       input logic [15:0] p,
                       input logic [15:0] ei,
                       input logic ef);
    chk({nm, ".req_ready"}, 32'(rr), 1);
    rv = 1'b1; pc = p; srdy = 1'b0;
    @(negedge clk);
    rv = 1'b0;
    chk({nm, ".wait_valid"}, 32'(sv), 0);
    chk({nm, ".wait_busy"}, 32'(bsy), 1);
    @(negedge clk);
    chk({nm, ".valid"}, 32'(sv), 1);
    chk({nm, ".instr"}, 32'(ins), 32'(ei));
    chk({nm, ".fault"}, 32'(flt), 32'(ef));
    srdy = 1'b1;
    @(negedge clk);
    srdy = 1'b0;
    chk({nm, ".idle_valid"}, 32'(sv), 0);
    chk({nm, ".idle_busy"}, 32'(bsy), 0);
  endtask

  initial begin
    vt[0] = '{16'd0,     16'h1111, 1'b0};
    vt[1] = '{16'd1,     16'h2222, 1'b0};
    vt[2] = '{16'd2,     16'h3333, 1'b0};
    vt[3] = '{16'd3,     16'h4444, 1'b0};
    vt[4] = '{16'd44,    16'hA5A5, 1'b0};
    vt[5] = '{16'd255,   16'h7777, 1'b0};
    vt[6] = '{16'd256,   16'h0000, 1'b1};
    vt[7] = '{16'hFFFF,  16'h0000, 1'b1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.valid", 32'(sv), 0);
    chk("rst.instr", 32'(ins), 0);
    chk("rst.fault", 32'(flt), 0);
    chk("rst.busy", 32'(bsy), 0);
    chk("rst.ready", 32'(rr), 1);
    chk("rst.ready0", 32'(rr0), 1);

    for (int i = 0; i < 16; i++)
      load(16'(i), (i < 4) ? 16'(16'h1111 * (i + 1))
                           : 16'(16'h0100 + i));
    load(16'd44, 16'hA5A5);
    load(16'd255, 16'h7777);
    load(16'd300, 16'hDEAD);
    load(16'hFFFF, 16'hBAD0);

    for (int i = 0; i < 8; i++)
      fetch($sformatf("vec%0d", i), vt[i].pc,
            vt[i].instr, vt[i].fault);

    // streaming on the zero-wait instance
    rv0 = 1'b1; pc0 = 16'd0; srdy0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("strm%0d.valid", i), 32'(sv0), 1);
      chk($sformatf("strm%0d.instr", i), 32'(ins0),
          32'(model[i]));
      if (i < 15) pc0 = 16'(i + 1);
      else rv0 = 1'b0;
    end
    @(negedge clk);
    srdy0 = 1'b0;
    chk("strm.end_valid", 32'(sv0), 0);
    chk("strm.end_busy", 32'(bsy0), 0);

    // backpressure with a queued follow-on request
    rv = 1'b1; pc = 16'd2; srdy = 1'b0;
    @(negedge clk);
    pc = 16'd3;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.valid", i), 32'(sv), 1);
      chk($sformatf("bp%0d.instr", i), 32'(ins), 32'h3333);
      chk($sformatf("bp%0d.ready", i), 32'(rr), 0);
      @(negedge clk);
    end
    srdy = 1'b1;
    #1 chk("bp.handoff_ready", 32'(rr), 1);
    @(negedge clk);
    rv = 1'b0;
    chk("bp.next_wait", 32'(sv), 0);
    chk("bp.next_busy", 32'(bsy), 1);
    @(negedge clk);
    chk("bp.next_valid", 32'(sv), 1);
    chk("bp.next_instr", 32'(ins), 32'h4444);
    @(negedge clk);
    srdy = 1'b0;
    chk("bp.idle", 32'(sv), 0);

    // load/read collision on pc 1
    rv = 1'b1; pc = 16'd1;
    @(negedge clk);
    rv = 1'b0;
    ld_en = 1'b1; ld_addr = 16'd1; ld_data = 16'hBEEF;
    @(negedge clk);
    ld_en = 1'b0;
    chk("col.valid", 32'(sv), 1);
    chk("col.instr", 32'(ins), 32'h2222);
    srdy = 1'b1;
    @(negedge clk);
    srdy = 1'b0;
    fetch("col.refetch", 16'd1, 16'hBEEF, 1'b0);

    // reset during WAIT
    rv = 1'b1; pc = 16'd3;
    @(negedge clk);
    rv = 1'b0;
    chk("mid.busy_before", 32'(bsy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.valid", 32'(sv), 0);
    chk("mid.instr", 32'(ins), 0);
    chk("mid.fault", 32'(flt), 0);
    chk("mid.busy", 32'(bsy), 0);
    chk("mid.ready", 32'(rr), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid.post%0d", i), 32'(sv), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
